// File: rtl/mul_stream_engine.sv
// mul_stream_engine
//   Job-framed operand streamer and pipelined multiplier. A start pulse
//   latches a job of len elements. The engine issues one A/B address pair
//   per cycle to two external memories. It realigns the returned data with
//   a valid/first/last tag pipeline and multiplies through MUL_STAGES
//   register stages. Products leave with out_valid/out_first/out_last, and
//   done is asserted alongside the final beat.
//
//   Optional build macro MUL_ACCUM_EN: products are summed in an internal
//   accumulator. A single out_valid beat then carries the job total.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start                job request, honoured only while idle
//   len/base_a/base_b/stride_b   job descriptor, sampled with start
//   busy                 job in progress
//   rd_en/addr_a/addr_b  memory read strobe and addresses
//   rdata_a/rdata_b      memory data, MEM_LAT cycles after rd_en
//   mul_output           product (or job sum), held between beats
//   out_valid/out_first/out_last  beat qualifiers
//   done                 one-cycle job-complete pulse
module mul_stream_engine #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 4,
   parameter int MEM_LAT    = 1,
   parameter int MUL_STAGES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W:0]       len,
   input  logic [ADDR_W-1:0]     base_a,
   input  logic [ADDR_W-1:0]     base_b,
   input  logic [ADDR_W-1:0]     stride_b,
   output logic                  busy,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     addr_a,
   output logic [ADDR_W-1:0]     addr_b,
   input  logic [DATA_W-1:0]     rdata_a,
   input  logic [DATA_W-1:0]     rdata_b,
   output logic [2*DATA_W-1:0]   mul_output,
   output logic                  out_valid,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  done
);

   localparam int STAGES = MEM_LAT + MUL_STAGES;
   localparam int PW     = 2 * DATA_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   typedef struct packed {
      logic [ADDR_W:0]   len;
      logic [ADDR_W-1:0] stride_b;
   } job_t;

   logic [1:0]        state;
   job_t              job_q;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_nxt;
   logic [ADDR_W:0]   cnt_nxt2;
   logic              last_issue;
   logic              zero_done;
   logic              beat_last;

   // Bit 0 is the issue stage itself (it is rd_en); bit STAGES is the
   // multiplier output stage.
   logic [STAGES:0]   vld_pipe;
   logic [STAGES:0]   first_pipe;
   logic [STAGES:0]   last_pipe;

   logic [PW-1:0]     prod_comb;
   logic [PW-1:0]     prod_reg [MUL_STAGES];

   assign cnt_nxt    = cnt + (ADDR_W+1)'(1);
   assign cnt_nxt2   = cnt + (ADDR_W+1)'(2);
   assign last_issue = (cnt_nxt == job_q.len);
   assign beat_last  = vld_pipe[STAGES] & last_pipe[STAGES];

   assign busy  = (state != IDLE);
   assign rd_en = vld_pipe[0];
   assign done  = beat_last | zero_done;

   // ---------------------------------------------------------------
   // Control FSM, address generation and tag pipeline
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         job_q      <= '0;
         cnt        <= '0;
         addr_a     <= '0;
         addr_b     <= '0;
         vld_pipe   <= '0;
         first_pipe <= '0;
         last_pipe  <= '0;
         zero_done  <= 1'b0;
      end else begin
         vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
         first_pipe[STAGES:1] <= first_pipe[STAGES-1:0];
         last_pipe[STAGES:1]  <= last_pipe[STAGES-1:0];
         zero_done            <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state          <= ISSUE;
                     job_q.len      <= len;
                     job_q.stride_b <= stride_b;
                     cnt            <= '0;
                     addr_a         <= base_a;
                     addr_b         <= base_b;
                     vld_pipe[0]    <= 1'b1;
                     first_pipe[0]  <= 1'b1;
                     last_pipe[0]   <= (len == (ADDR_W+1)'(1));
                  end else begin
                     // An empty job completes without touching memory.
                     zero_done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (last_issue) begin
                  state         <= DRAIN;
                  vld_pipe[0]   <= 1'b0;
                  first_pipe[0] <= 1'b0;
                  last_pipe[0]  <= 1'b0;
               end else begin
                  cnt           <= cnt_nxt;
                  addr_a        <= addr_a + ADDR_W'(1);
                  addr_b        <= addr_b + job_q.stride_b;
                  first_pipe[0] <= 1'b0;
                  // Tag the upcoming element if it is the final one.
                  last_pipe[0]  <= (cnt_nxt2 == job_q.len);
               end
            end
            DRAIN: begin
               if (beat_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Multiplier pipeline. Each stage only loads when the beat entering
   // it is valid, so the final stage naturally holds between beats.
   // ---------------------------------------------------------------
   assign prod_comb = {{DATA_W{1'b0}}, rdata_a} * {{DATA_W{1'b0}}, rdata_b};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MUL_STAGES; i++) prod_reg[i] <= '0;
      end else begin
         if (vld_pipe[MEM_LAT]) prod_reg[0] <= prod_comb;
         for (int i = 1; i < MUL_STAGES; i++) begin
            if (vld_pipe[MEM_LAT+i]) prod_reg[i] <= prod_reg[i-1];
         end
      end
   end

`ifdef MUL_ACCUM_EN
   // ---------------------------------------------------------------
   // Accumulating output: the running sum is added combinationally to the
   // product at the output stage, so the total appears in the same cycle
   // the last product would have. A separate register holds the reported
   // sum between jobs, and intermediate partial sums stay internal.
   // ---------------------------------------------------------------
   logic [PW-1:0] acc;
   logic [PW-1:0] acc_sum;
   logic [PW-1:0] res_hold;

   // The first beat restarts from zero. This also guards against any stale
   // value if a job starts immediately after the previous one.
   assign acc_sum = (first_pipe[STAGES] ? '0 : acc) + prod_reg[MUL_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         res_hold <= '0;
      end else begin
         if (state == IDLE && start)  acc <= '0;
         else if (vld_pipe[STAGES])   acc <= acc_sum;
         if (beat_last)               res_hold <= acc_sum;
      end
   end

   assign out_valid  = beat_last;
   assign out_first  = beat_last;
   assign out_last   = beat_last;
   assign mul_output = beat_last ? acc_sum : res_hold;
`else
   assign out_valid  = vld_pipe[STAGES];
   assign out_first  = vld_pipe[STAGES] & first_pipe[STAGES];
   assign out_last   = beat_last;
   assign mul_output = prod_reg[MUL_STAGES-1];
`endif

endmodule

// File: tb/tb_mul_stream_engine.sv
// Self-checking bench for mul_stream_engine (default parameters).
// Expected behaviour comes from a job-level model: for each job, the bench
// knows which relative cycle each beat must appear in, and the product or
// sum it must carry. The model is computed from the memory contents
// and the job descriptor. Honours MUL_ACCUM_EN when the DUT is built with it.
module tb_mul_stream_engine;
   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int ML  = 1;
   localparam int MS  = 4;
   localparam int LAT = ML + MS;
   localparam int DEPTH = 1 << AW;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW:0]     len;
   logic [AW-1:0]   base_a, base_b, stride_b;
   logic            busy, rd_en;
   logic [AW-1:0]   addr_a, addr_b;
   logic [DW-1:0]   rdata_a, rdata_b;
   logic [2*DW-1:0] mul_output;
   logic            out_valid, out_first, out_last, done;

   logic [DW-1:0]   mem_a [DEPTH];
   logic [DW-1:0]   mem_b [DEPTH];

   int              checks = 0;
   int              failures = 0;
   logic [63:0]     exp_hold;

   mul_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(ML), .MUL_STAGES(MS)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .base_a(base_a), .base_b(base_b), .stride_b(stride_b),
      .busy(busy), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .mul_output(mul_output),
      .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
      .done(done)
   );

   always #5 clk = ~clk;

   // Single-cycle-latency synchronous memories.
   always @(posedge clk) begin
      if (rd_en) begin
         rdata_a <= mem_a[addr_a];
         rdata_b <= mem_b[addr_b];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_plan();
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = DW'(i + 1);
         mem_b[i] = DW'(2 * i);
      end
   endtask

   function automatic logic [63:0] prod(input int ba, input int bb, input int st, input int k);
      logic [63:0] pa, pb;
      pa = {32'b0, mem_a[(ba + k) % DEPTH]};
      pb = {32'b0, mem_b[(bb + k * st) % DEPTH]};
      return pa * pb;
   endfunction

   // Runs one job from the current sample point, checking every cycle until
   // busy has dropped. inj>0 pulses a conflicting start at that cycle.
   task automatic run_job(input int n, input int ba, input int bb, input int st, input int inj);
      int c_end;
      int k;
      bit ev, ef, el, ed, er, eb;
      logic [63:0] sum;
      len = (AW+1)'(n); base_a = AW'(ba); base_b = AW'(bb); stride_b = AW'(st);
      start = 1'b1;
      step();
      start = 1'b0;
      // Descriptor inputs wander during the job; the DUT must ignore them.
      len = (AW+1)'($urandom_range(1, DEPTH));
      base_a = AW'($urandom); base_b = AW'($urandom); stride_b = AW'($urandom);
      c_end = (n == 0) ? 2 : n + LAT + 1;
      sum = '0;
      for (int j = 0; j < n; j++) sum += prod(ba, bb, st, j);
      for (int c = 1; c <= c_end; c++) begin
         k  = c - 1 - LAT;
         er = (c <= n);
         eb = (n != 0) && (c <= n + LAT);
         ed = (n == 0) ? (c == 1) : (c == n + LAT);
`ifdef MUL_ACCUM_EN
         ev = (n != 0) && (c == n + LAT);
         ef = ev;
         el = ev;
         if (ev) exp_hold = sum;
`else
         ev = (k >= 0) && (k < n);
         ef = ev && (k == 0);
         el = ev && (k == n - 1);
         if (ev) exp_hold = prod(ba, bb, st, k);
`endif
         chk("rd_en", 64'(rd_en), 64'(er));
         chk("busy", 64'(busy), 64'(eb));
         chk("out_valid", 64'(out_valid), 64'(ev));
         chk("out_first", 64'(out_first), 64'(ef));
         chk("out_last", 64'(out_last), 64'(el));
         chk("done", 64'(done), 64'(ed));
         chk("mul_output", mul_output, exp_hold);
         if (er) begin
            chk("addr_a", 64'(addr_a), 64'((ba + c - 1) % DEPTH));
            chk("addr_b", 64'(addr_b), 64'((bb + (c - 1) * st) % DEPTH));
         end
         start = (c == inj);
         if (start) len = (AW+1)'($urandom_range(1, DEPTH));
         if (c < c_end) step();
      end
      start = 1'b0;
   endtask

   task automatic reset_mid_job();
      len = 5'd8; base_a = 4'd3; base_b = 4'd1; stride_b = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      // Third issue cycle: element 2.
      chk("mid_rd_en", 64'(rd_en), 64'd1);
      chk("mid_addr_a", 64'(addr_a), 64'd5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_hold = '0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_addr_a", 64'(addr_a), 64'd0);
      chk("rst_addr_b", 64'(addr_b), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_first_last", 64'({out_first, out_last}), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mul_output", mul_output, 64'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("post_rst_out_valid", 64'(out_valid), 64'd0);
         chk("post_rst_done", 64'(done), 64'd0);
         chk("post_rst_busy", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int n, inj;
      reset = 1'b1; start = 1'b0; len = '0;
      base_a = '0; base_b = '0; stride_b = '0;
      exp_hold = '0;
      fill_plan();
      repeat (3) step();
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rd_en", 64'(rd_en), 64'd0);
      chk("reset_flags", 64'({out_valid, out_first, out_last, done}), 64'd0);
      chk("reset_addrs", 64'({addr_a, addr_b}), 64'd0);
      chk("reset_mul_output", mul_output, 64'd0);
      reset = 1'b0;
      step();

      run_job(4, 0, 0, 1, 0);     // products 0,4,12,24 (sum 40 when accumulating)
      run_job(4, 14, 13, 3, 0);   // address wrap: 390,0,6,24
      run_job(0, 5, 5, 1, 0);     // empty job: done only
      run_job(8, 2, 3, 5, 2);     // start during ISSUE must be ignored
      reset_mid_job();

      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = 32'hFFFF_FFFF;
         mem_b[i] = 32'hFFFF_FFFF;
      end
      run_job(1, 7, 9, 2, 0);
      chk("max_product_held", mul_output, 64'hFFFF_FFFE_0000_0001);

      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = $urandom;
         mem_b[i] = $urandom;
      end
      for (int j = 0; j < 10; j++) begin
         n   = $urandom_range(0, DEPTH);
         inj = (n == 0) ? 0 : $urandom_range(1, n + LAT);
         run_job(n, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, DEPTH - 1), inj);
      end

      fill_plan();
      run_job(16, 0, 0, 1, 0);    // full-length job

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mul_stream_engine.md
Name: mul_stream_engine

Overview:
Parametrised successor to the fixed A×B multiplier front-end. It generates address streams for two external operand memories, aligns the read data with a valid pipeline, and multiplies through an internal pipelined multiplier of configurable depth. Each run is a job framed by a start/done handshake with programmable length, base addresses and B stride. It replaces the hard-coded delayed-enable and counter-bypass pulses with aligned out_valid, out_first and out_last flags, and sits between the operand BRAMs and the accumulator.

Parameters:
DATA_W, 32, operand width; product is 2*DATA_W.
ADDR_W, 4, operand memory address width.
MEM_LAT, 1, read latency of the external memories in cycles (>=1).
MUL_STAGES, 4, multiplier pipeline register stages (>=1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  job request pulse, accepted only in IDLE
len  in  ADDR_W+1  element count, 0..2^ADDR_W; sampled at start
base_a  in  ADDR_W  first A address; sampled at start
base_b  in  ADDR_W  first B address; sampled at start
stride_b  in  ADDR_W  B address increment per element; sampled at start
busy  out  1  job in progress
rd_en  out  1  memory read strobe
addr_a  out  ADDR_W  A read address
addr_b  out  ADDR_W  B read address
rdata_a  in  DATA_W  A read data, valid MEM_LAT cycles after rd_en
rdata_b  in  DATA_W  B read data, valid MEM_LAT cycles after rd_en
mul_output  out  2*DATA_W  product
out_valid  out  1  mul_output valid this cycle
out_first  out  1  first beat of job
out_last  out  1  final beat of job
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset: state IDLE. busy, rd_en, out_valid, out_first, out_last, done, addr_a, addr_b and mul_output are all 0. The valid/first/last shift pipelines are cleared.
- FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with len!=0: latch the parameters, go to ISSUE; busy=1 from the next cycle.
  - start with len==0: stay IDLE; done pulses the next cycle; busy stays 0; no reads.
- ISSUE:
  - rd_en=1 every cycle; one address pair per cycle, len cycles in total.
  - Element k: addr_a = base_a + k mod 2^ADDR_W; addr_b = base_b + k*stride_b mod 2^ADDR_W. Both wrap silently.
  - After the len-th issue, go to DRAIN; rd_en=0.
- DRAIN: wait until the last tagged beat leaves the pipeline, then return to IDLE.
- Latency: a read issued in cycle t gives out_valid in cycle t+MEM_LAT+MUL_STAGES. Beats are consecutive, with no bubbles.
- Arithmetic: unsigned DATA_W×DATA_W product, full 2*DATA_W result, no truncation.
- mul_output holds its last value when out_valid=0.
- Flags:
  - out_first marks element 0; out_last marks element len-1. Both are asserted together when len==1.
  - done is asserted in the same cycle as out_last. busy drops the following cycle. A start in that following cycle is accepted, so back-to-back jobs have a 1-cycle gap at the issue side.
- start while busy=1 is ignored, with no effect on the running job.
- Parameters are latched at start; input changes during a job have no effect.
- Reset mid-job takes effect the next cycle: everything returns to reset values and in-flight beats are discarded. No out_valid or done appears afterwards.

Optional Feature:
MUL_ACCUM_EN
- Defined: products are summed into an internal 2*DATA_W accumulator. The accumulator is cleared at each job start and wraps mod 2^(2*DATA_W).
  - out_valid pulses exactly once per job, on the cycle the last product would have appeared, carrying the sum; out_first, out_last and done are asserted together with it.
  - Adds zero latency beyond the per-element case. len==0 behaves as in IDLE: no beat, done only.
- Undefined: per-element products as above; no accumulator logic.

Test Plan:
The bench memory model uses A[i]=i+1 and B[i]=2i.
1. base_a=0, base_b=0, stride_b=1, len=4, defaults -> out_valid at start+1+5 for 4 consecutive cycles with mul_output 0,4,12,24. out_first on beat 0; out_last and done on beat 3; busy low the next cycle.
2. base_a=14, base_b=13, stride_b=3, len=4 -> addr_a 14,15,0,1; addr_b 13,0,3,6; products 15*26=390, 16*0=0, 1*6=6, 2*12=24.
3. len=0 start -> done 1 cycle later; rd_en, busy and out_valid stay 0.
4. Second start during ISSUE of a len=8 job -> ignored, exactly 8 beats. Assert reset at the 3rd issue cycle -> all outputs 0 the next cycle, and no out_valid or done for 10 cycles.
5. Memories return 0xFFFFFFFF for both operands, len=1 -> single beat 0xFFFFFFFE00000001 with out_first, out_last and done all high.
6. With MUL_ACCUM_EN, repeat scenario 1 -> single out_valid beat of 40 at the 4th-beat cycle, with first, last and done high.
